// File: rtl/cp0_pkg.sv
// CP0 register indices, exception codes, SR/Cause bit positions and FSM state type.
package cp0_pkg;

  localparam int unsigned CP0_REG_W  = 5;
  localparam int unsigned CP0_DATA_W = 32;
  localparam int unsigned EXC_CODE_W = 5;
  localparam int unsigned HW_INT_W   = 6;

  localparam logic [CP0_REG_W-1:0] CP0_REG_COUNT   = CP0_REG_W'(9);
  localparam logic [CP0_REG_W-1:0] CP0_REG_COMPARE = CP0_REG_W'(11);
  localparam logic [CP0_REG_W-1:0] CP0_REG_SR      = CP0_REG_W'(12);
  localparam logic [CP0_REG_W-1:0] CP0_REG_CAUSE   = CP0_REG_W'(13);
  localparam logic [CP0_REG_W-1:0] CP0_REG_EPC     = CP0_REG_W'(14);
  localparam logic [CP0_REG_W-1:0] CP0_REG_PRID    = CP0_REG_W'(15);

  localparam logic [EXC_CODE_W-1:0] EXC_INT  = EXC_CODE_W'(0);
  localparam logic [EXC_CODE_W-1:0] EXC_ADEL = EXC_CODE_W'(4);
  localparam logic [EXC_CODE_W-1:0] EXC_ADES = EXC_CODE_W'(5);
  localparam logic [EXC_CODE_W-1:0] EXC_RI   = EXC_CODE_W'(10);
  localparam logic [EXC_CODE_W-1:0] EXC_OV   = EXC_CODE_W'(12);

  localparam int unsigned SR_IE_BIT    = 0;
  localparam int unsigned SR_EXL_BIT   = 1;
  localparam int unsigned SR_IM_LO     = 10;
  localparam int unsigned SR_IM_HI     = 15;
  localparam int unsigned CAUSE_BD_BIT = 31;
  localparam int unsigned CAUSE_IP_LO  = 10;
  localparam int unsigned CAUSE_IP_HI  = 15;
  localparam int unsigned CAUSE_EXC_LO = 2;
  localparam int unsigned CAUSE_EXC_HI = 6;

  localparam logic [CP0_DATA_W-1:0] CP0_HANDLER = 32'h0000_4180;

  // NORMAL mirrors EXL=0, HANDLER mirrors EXL=1
  typedef enum logic {
    ST_NORMAL  = 1'b0,
    ST_HANDLER = 1'b1
  } cp0_state_e;

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: Count free-runs and wraps, TI latches on match until Compare is rewritten.
module cp0_timer
  import cp0_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  count_we,
  input  logic                  compare_we,
  input  logic [CP0_DATA_W-1:0] wd,
  output logic [CP0_DATA_W-1:0] count,
  output logic [CP0_DATA_W-1:0] compare,
  output logic                  ti
);

  // Count increments every cycle unless written; a Compare write clears TI over a same-cycle match
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count   <= '0;
      compare <= '0;
      ti      <= 1'b0;
    end else begin
      count <= count_we ? wd : CP0_DATA_W'(count + CP0_DATA_W'(1));
      if (compare_we) begin
        compare <= wd;
        ti      <= 1'b0;
      end else if (count == compare) begin
        ti <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_exc_unit.sv
// MEM-stage CP0 and exception responder: SR/Cause/EPC/PRId, interrupt vs exception arbitration,
// mfc0/mtc0/eret. Define CP0_TIMER_EN to build in Count/Compare and the timer interrupt on IP[15].
module cp0_exc_unit
  import cp0_pkg::*;
#(
  parameter logic [CP0_DATA_W-1:0] PRID_VAL = 32'h0000_7001
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CP0_DATA_W-1:0] PC_MEM,
  input  logic                  br_j_MEM,
  input  logic                  PC_err_MEM,
  input  logic                  RI_MEM,
  input  logic                  overflow_MEM,
  input  logic                  adel_MEM,
  input  logic                  ades_MEM,
  input  logic                  eret_MEM,
  input  logic                  mtc0_MEM,
  input  logic [CP0_REG_W-1:0]  c0_WA_MEM,
  input  logic [CP0_REG_W-1:0]  c0_RA_MEM,
  input  logic [CP0_DATA_W-1:0] c0_WD,
  input  logic [HW_INT_W-1:0]   HWInt,
  output logic [CP0_DATA_W-1:0] c0_RD,
  output logic [CP0_DATA_W-1:0] EPC,
  output logic                  IntReq
);

  cp0_state_e                state;
  logic [HW_INT_W-1:0]       sr_im;
  logic                      sr_ie;
  logic                      cause_bd;
  logic [HW_INT_W-1:0]       cause_ip;
  logic [EXC_CODE_W-1:0]     cause_exc;
  logic [CP0_DATA_W-1:0]     epc_q;
  logic                      exl;
  logic [HW_INT_W-1:0]       ip_live;
  logic                      int_pend;
  logic                      exc_any;
  logic                      mtc0_ok;
  logic [EXC_CODE_W-1:0]     exc_code;
  logic [CP0_DATA_W-1:0]     rd_mux;

  assign exl = (state == ST_HANDLER);

`ifdef CP0_TIMER_EN
  logic [CP0_DATA_W-1:0] count;
  logic [CP0_DATA_W-1:0] compare;
  logic                  ti;

  cp0_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .count_we   (mtc0_ok && (c0_WA_MEM == CP0_REG_COUNT)),
    .compare_we (mtc0_ok && (c0_WA_MEM == CP0_REG_COMPARE)),
    .wd         (c0_WD),
    .count      (count),
    .compare    (compare),
    .ti         (ti)
  );

  assign ip_live = {HWInt[HW_INT_W-1] | ti, HWInt[HW_INT_W-2:0]};
`else
  assign ip_live = HWInt;
`endif

  // Interrupt uses live lines so it is taken in the same cycle the line rises
  assign int_pend = (|(ip_live & sr_im)) & sr_ie & ~exl;
  assign exc_any  = PC_err_MEM | RI_MEM | overflow_MEM | adel_MEM | ades_MEM;
  assign IntReq   = reset & (int_pend | (exc_any & ~exl));
  assign mtc0_ok  = mtc0_MEM & ~IntReq;
  assign EPC      = epc_q;

  // Exception code by fixed priority
  always_comb begin
    exc_code = EXC_INT;
    if (int_pend)          exc_code = EXC_INT;
    else if (PC_err_MEM)   exc_code = EXC_ADEL;
    else if (RI_MEM)       exc_code = EXC_RI;
    else if (overflow_MEM) exc_code = EXC_OV;
    else if (adel_MEM)     exc_code = EXC_ADEL;
    else if (ades_MEM)     exc_code = EXC_ADES;
  end

  // mfc0 read mux; returns pre-write values, forced to zero while in reset
  always_comb begin
    rd_mux = '0;
    case (c0_RA_MEM)
      CP0_REG_SR: begin
        rd_mux[SR_IM_HI:SR_IM_LO] = sr_im;
        rd_mux[SR_EXL_BIT]        = exl;
        rd_mux[SR_IE_BIT]         = sr_ie;
      end
      CP0_REG_CAUSE: begin
        rd_mux[CAUSE_BD_BIT]                = cause_bd;
        rd_mux[CAUSE_IP_HI:CAUSE_IP_LO]     = cause_ip;
        rd_mux[CAUSE_EXC_HI:CAUSE_EXC_LO]   = cause_exc;
      end
      CP0_REG_EPC:     rd_mux = epc_q;
      CP0_REG_PRID:    rd_mux = PRID_VAL;
`ifdef CP0_TIMER_EN
      CP0_REG_COUNT:   rd_mux = count;
      CP0_REG_COMPARE: rd_mux = compare;
`endif
      default:         rd_mux = '0;
    endcase
    c0_RD = reset ? rd_mux : '0;
  end

  // State and CP0 registers: exception beats eret and mtc0; eret beats an SR write for EXL
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_NORMAL;
      sr_im     <= '0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= '0;
      cause_exc <= EXC_INT;
      epc_q     <= '0;
    end else begin
      cause_ip <= ip_live;
      if (IntReq) begin
        state     <= ST_HANDLER;
        cause_exc <= exc_code;
        cause_bd  <= br_j_MEM;
        epc_q     <= br_j_MEM ? CP0_DATA_W'(PC_MEM - CP0_DATA_W'(4)) : PC_MEM;
      end else begin
        if (mtc0_ok && (c0_WA_MEM == CP0_REG_SR)) begin
          sr_im <= c0_WD[SR_IM_HI:SR_IM_LO];
          sr_ie <= c0_WD[SR_IE_BIT];
          state <= c0_WD[SR_EXL_BIT] ? ST_HANDLER : ST_NORMAL;
        end
        if (mtc0_ok && (c0_WA_MEM == CP0_REG_EPC)) begin
          epc_q <= {c0_WD[CP0_DATA_W-1:2], 2'b00};
        end
        if (eret_MEM) begin
          state <= ST_NORMAL;
        end
      end
    end
  end

endmodule
